// File: rtl/rob_reorder_stage.sv
// rob_reorder_stage: response-side reorder stage of the reorder buffer.
// Out-of-order tagged responses are parked in per-tag slots and released
// to the consumer strictly in issue order, following the tag at the head
// of the order fifo.
//
// Optional feature: define ROB_REORDER_BYPASS_EN to let a response whose
// tag is the current head go straight into the output register when that
// register is free, skipping the slot (one cycle less latency).
//
// Handshake: out_valid/out_data/out_tag are registered; a transfer happens
// on a rising edge where out_valid=1 and out_ready=1. While out_valid=1 and
// out_ready=0 the output holds. The response side has no ready: every
// rsp_valid is consumed (parked, bypassed or flagged as a duplicate).
module rob_reorder_stage #(
  parameter  int WIDTH = 8,
  parameter  int TAGS  = 4,
  localparam int TAG_W = $clog2(TAGS),
  localparam int CNT_W = $clog2(TAGS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             order_empty,
  input  logic [TAG_W-1:0] order_tag,
  output logic             order_pop,
  input  logic             rsp_valid,
  input  logic [TAG_W-1:0] rsp_tag,
  input  logic [WIDTH-1:0] rsp_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] pending,
  output logic             err_dup
);

  logic [TAGS-1:0]  slot_vld_q, slot_vld_d;
  logic [WIDTH-1:0] slot_data_q [TAGS];
  logic             out_valid_q;
  logic [TAG_W-1:0] out_tag_q;
  logic [WIDTH-1:0] out_data_q;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             err_dup_q;

  logic rsp_in_range;
  logic head_in_range;
  logic rsp_slot_vld;
  logic head_vld;
  logic out_free;
  logic rel;
  logic bypass;
  logic rsp_accept;
  logic rsp_dup;

  // Tags at or beyond TAGS only exist when TAGS is not a power of two.
  if (TAGS == (1 << TAG_W)) begin : g_full_range
    assign rsp_in_range  = 1'b1;
    assign head_in_range = 1'b1;
  end else begin : g_part_range
    assign rsp_in_range  = (32'(rsp_tag) < TAGS);
    assign head_in_range = (32'(order_tag) < TAGS);
  end

  assign rsp_slot_vld = rsp_in_range & slot_vld_q[rsp_tag];
  assign head_vld     = ~order_empty & head_in_range & slot_vld_q[order_tag];
  assign out_free     = ~out_valid_q | out_ready;
  assign rel          = out_free & head_vld;

`ifdef ROB_REORDER_BYPASS_EN
  // Head response with an empty slot and a free output goes straight out.
  // rel is necessarily 0 here because the head slot is empty.
  assign bypass = rsp_valid & rsp_in_range & ~order_empty &
                  (rsp_tag == order_tag) & ~rsp_slot_vld & out_free;
`else
  assign bypass = 1'b0;
`endif

  // A slot that is valid before the edge rejects a new response, even if
  // that slot is being released at the same edge.
  assign rsp_accept = rsp_valid & rsp_in_range & ~rsp_slot_vld & ~bypass;
  assign rsp_dup    = rsp_valid & (~rsp_in_range | rsp_slot_vld);

  assign order_pop = rel | bypass;

  // Next slot occupancy: release the head, park an accepted response.
  // Both never target the same slot (accept needs it empty, release full).
  always_comb begin
    slot_vld_d = slot_vld_q;
    if (rel)        slot_vld_d[order_tag] = 1'b0;
    if (rsp_accept) slot_vld_d[rsp_tag]   = 1'b1;
  end

  // Occupancy counter: +1 on park, -1 on release, unchanged on both.
  always_comb begin
    pending_d = pending_q;
    case ({rsp_accept, rel})
      2'b10:   pending_d = pending_q + CNT_W'(1);
      2'b01:   pending_d = pending_q - CNT_W'(1);
      default: pending_d = pending_q;
    endcase
  end

  // Slot valid bits, counter and sticky duplicate flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld_q <= '0;
      pending_q  <= '0;
      err_dup_q  <= 1'b0;
    end else begin
      slot_vld_q <= slot_vld_d;
      pending_q  <= pending_d;
      if (rsp_dup) err_dup_q <= 1'b1;
    end
  end

  // Slot payload storage; contents are meaningless while the valid bit is 0.
  always_ff @(posedge clk) begin
    if (rsp_accept) slot_data_q[rsp_tag] <= rsp_data;
  end

  // Output register: load on release or bypass, drop after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_data_q  <= '0;
    end else if (bypass) begin
      out_valid_q <= 1'b1;
      out_tag_q   <= rsp_tag;
      out_data_q  <= rsp_data;
    end else if (rel) begin
      out_valid_q <= 1'b1;
      out_tag_q   <= order_tag;
      out_data_q  <= slot_data_q[order_tag];
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_tag   = out_tag_q;
  assign out_data  = out_data_q;
  assign pending   = pending_q;
  assign err_dup   = err_dup_q;

endmodule

// File: tb/tb_rob_reorder_stage.sv
// Bench for rob_reorder_stage: the bench plays the order fifo, issues
// tagged requests with pre-chosen data, returns responses out of order and
// compares the DUT against a slot-array reference plus an in-order stream.
module tb_rob_reorder_stage;

  localparam int WIDTH = 8;
  localparam int TAGS  = 4;
  localparam int TAG_W = 2;
  localparam int CNT_W = 3;
`ifdef ROB_REORDER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic             order_empty;
  logic [TAG_W-1:0] order_tag;
  logic             order_pop;
  logic             rsp_valid;
  logic [TAG_W-1:0] rsp_tag;
  logic [WIDTH-1:0] rsp_data;
  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] out_tag;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] pending;
  logic             err_dup;

  rob_reorder_stage #(.WIDTH(WIDTH), .TAGS(TAGS)) dut (
    .clk(clk), .rst_n(rst_n),
    .order_empty(order_empty), .order_tag(order_tag), .order_pop(order_pop),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_data(out_data), .pending(pending), .err_dup(err_dup)
  );

  // bench-owned order fifo and expected in-order output stream
  logic [TAG_W-1:0]       fifo_q[$];
  logic [TAG_W+WIDTH-1:0] exp_q[$];
  int                     await_q[$];
  bit                     in_use[TAGS];
  logic [WIDTH-1:0]       issued_dat[TAGS];

  // reference: parked responses per tag, output register, sticky error
  bit               m_vld[TAGS];
  logic [WIDTH-1:0] m_dat[TAGS];
  bit               m_ov;
  logic [TAG_W-1:0] m_ot;
  logic [WIDTH-1:0] m_od;
  bit               m_err;

  int n_vec = 0;
  int n_err = 0;
  bit obs_ov;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int parked_count();
    int c = 0;
    for (int i = 0; i < TAGS; i++) if (m_vld[i]) c++;
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < TAGS; i++) begin
      m_vld[i] = 1'b0;
      in_use[i] = 1'b0;
    end
    m_ov = 1'b0; m_ot = '0; m_od = '0; m_err = 1'b0;
    fifo_q.delete(); exp_q.delete(); await_q.delete();
  endtask

  task automatic push_order(input logic [TAG_W-1:0] tag, input logic [WIDTH-1:0] data);
    fifo_q.push_back(tag);
    exp_q.push_back({tag, data});
    await_q.push_back(int'(tag));
    in_use[tag] = 1'b1;
    issued_dat[tag] = data;
  endtask

  // driver: one clock cycle of stimulus, checks and reference update
  task automatic cycle(input bit rv, input logic [TAG_W-1:0] rt,
                       input logic [WIDTH-1:0] rd, input bit rdy);
    logic [TAG_W-1:0]       head;
    bit                     nonempty, free, rel, byp, dup;
    logic [TAG_W+WIDTH-1:0] e;
    @(negedge clk);
    nonempty    = (fifo_q.size() != 0);
    head        = nonempty ? fifo_q[0] : TAG_W'($urandom_range(0, TAGS - 1));
    order_empty = !nonempty;
    order_tag   = head;
    rsp_valid   = rv;
    rsp_tag     = rt;
    rsp_data    = rd;
    out_ready   = rdy;
    #1;
    obs_ov = out_valid;
    check("out_valid", out_valid, m_ov);
    check("out_tag", out_tag, m_ot);
    check("out_data", out_data, m_od);
    check("pending", pending, parked_count());
    check("err_dup", err_dup, m_err);
    if (out_valid && rdy) begin
      if (exp_q.size() == 0) check("extra_output", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("stream", {out_tag, out_data}, e);
      end
    end
    free = !m_ov || rdy;
    rel  = nonempty && free && m_vld[head];
    byp  = BYP && rv && nonempty && (rt == head) && !m_vld[rt] && free;
    dup  = rv && m_vld[rt];
    check("order_pop", order_pop, rel || byp);
    if (rel) begin
      m_ov = 1'b1; m_ot = head; m_od = m_dat[head];
      m_vld[head] = 1'b0; in_use[head] = 1'b0;
    end else if (byp) begin
      m_ov = 1'b1; m_ot = rt; m_od = rd; in_use[rt] = 1'b0;
    end else if (rdy) begin
      m_ov = 1'b0;
    end
    if (dup) m_err = 1'b1;
    else if (rv && !byp) begin
      m_vld[rt] = 1'b1; m_dat[rt] = rd;
    end
    if (rel || byp) void'(fifo_q.pop_front());
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || m_ov) && n < budget) begin
      cycle(1'b0, '0, '0, 1'b1);
      n++;
    end
    check(tag, exp_q.size() + int'(m_ov), 0);
  endtask

  initial begin
    int lat, run, best, start, pick, idx;
    logic [WIDTH-1:0] d8[8];
    logic [TAG_W-1:0] t;
    bit               rv, found;

    rst_n = 1'b0; order_empty = 1'b1; order_tag = '0;
    rsp_valid = 1'b0; rsp_tag = '0; rsp_data = '0; out_ready = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_data", out_data, 0);
    check("rst_pending", pending, 0);
    check("rst_err_dup", err_dup, 0);
    check("rst_order_pop", order_pop, 0);
    rst_n = 1'b1;

    // out-of-order responses 3,1,0,2 with consumer always ready
    for (int i = 0; i < 4; i++) push_order(TAG_W'(i), WIDTH'(8'hA0 + i));
    cycle(1, 2'd3, 8'hA3, 1); cycle(1, 2'd1, 8'hA1, 1);
    cycle(1, 2'd0, 8'hA0, 1); cycle(1, 2'd2, 8'hA2, 1);
    drain("drain_in_order", 20);

    // same pattern, consumer stalled for a while after the first output
    await_q.delete();
    for (int i = 0; i < 4; i++) push_order(TAG_W'(i), WIDTH'(8'hA0 + i));
    cycle(1, 2'd3, 8'hA3, 0); cycle(1, 2'd1, 8'hA1, 0);
    cycle(1, 2'd0, 8'hA0, 0); cycle(1, 2'd2, 8'hA2, 0);
    repeat (5) cycle(0, '0, '0, 0);
    check("stall_pending", pending, 3);
    check("stall_hold_data", out_data, 8'hA0);
    drain("drain_stall", 20);

    // latency from response to out_valid with tag already at the head
    await_q.delete();
    push_order(2'd1, 8'h7E);
    cycle(1, 2'd1, 8'h7E, 1);
    lat = 0;
    for (int k = 1; k <= 5; k++) begin
      cycle(0, '0, '0, 1);
      if (obs_ov && lat == 0) lat = k;
    end
    check("latency", lat, BYP ? 1 : 2);
    drain("drain_latency", 5);

    // back-to-back in-order responses, tags cycling 0..3
    await_q.delete();
    for (int i = 0; i < 8; i++) begin
      d8[i] = WIDTH'($urandom);
      push_order(TAG_W'(i % 4), d8[i]);
    end
    run = 0; best = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 8) cycle(1, TAG_W'(i % 4), d8[i], 1);
      else cycle(0, '0, '0, 1);
      run  = obs_ov ? run + 1 : 0;
      best = (run > best) ? run : best;
    end
    check("b2b_run", best, 8);
    check("b2b_err", err_dup, 0);
    drain("drain_b2b", 5);

    // randomized issue / response / consumer traffic, no duplicates
    await_q.delete();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        start = $urandom_range(0, TAGS - 1);
        found = 1'b0;
        for (int k = 0; k < TAGS; k++) begin
          pick = (start + k) % TAGS;
          if (!found && !in_use[pick]) begin
            found = 1'b1;
            push_order(TAG_W'(pick), WIDTH'($urandom));
          end
        end
      end
      rv = 1'b0; t = '0;
      if (await_q.size() != 0 && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, await_q.size() - 1);
        t = TAG_W'(await_q[idx]);
        await_q.delete(idx);
        rv = 1'b1;
      end
      cycle(rv, t, issued_dat[t], $urandom_range(0, 3) != 0);
    end
    for (int c = 0; c < 100 && await_q.size() != 0; c++) begin
      t = TAG_W'(await_q.pop_front());
      cycle(1, t, issued_dat[t], 1);
    end
    drain("drain_random", 100);

    // duplicate response for a parked tag: first data wins, error sticks
    await_q.delete();
    push_order(2'd0, 8'h10);
    push_order(2'd2, 8'h55);
    cycle(1, 2'd2, 8'h55, 1);
    cycle(1, 2'd2, 8'h66, 1);
    cycle(1, 2'd0, 8'h10, 1);
    check("dup_sticky", err_dup, 1);
    drain("drain_dup", 10);
    check("dup_still_set", err_dup, 1);

    // asynchronous reset while slots are occupied and output is held
    await_q.delete();
    for (int i = 0; i < 4; i++) push_order(TAG_W'(i), WIDTH'(8'hB0 + i));
    cycle(1, 2'd0, 8'hB0, 0);
    cycle(1, 2'd1, 8'hB1, 0);
    cycle(1, 2'd2, 8'hB2, 0);
    cycle(0, '0, '0, 0);
    check("pre_reset_pending", pending, 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_pending", pending, 0);
    check("async_err_dup", err_dup, 0);
    check("async_out_data", out_data, 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    push_order(2'd3, 8'hC3);
    cycle(1, 2'd3, 8'hC3, 1);
    drain("drain_after_reset", 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
